// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer: FSM state encoding,
// block geometry and the default round count.
// Latency: n/a (types and constants only). Backpressure: n/a.
package aes_round_sequencer_pkg;

  localparam int BYTES_PER_BLOCK    = 16;
  localparam int DEFAULT_NUM_ROUNDS = 10;

  localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // True on the last byte of a 16-cycle phase.
  function automatic logic is_last_byte(input logic [3:0] b);
    return b == LAST_BYTE;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_counter.sv
// Byte index counter for one 16-byte phase; wraps 15 -> 0 on its own.
// Latency: count updates on the edge after en/clr. Backpressure: none, free-running when enabled.
// Ports: clk, rst (async, active-high), en (advance), clr (sync clear, wins over en), count[3:0].
module aes_round_sequencer_counter
  import aes_round_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en) begin
      count <= (count == LAST_BYTE) ? 4'd0 : count + 4'd1;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequencer for the byte-serial AES encrypt datapath: load, NUM_ROUNDS rounds, output drain.
// Latency: done pulses 16*(NUM_ROUNDS+2) cycles after the cycle in which start is sampled.
// Backpressure: none; every phase runs exactly 16 cycles, abort cancels the block.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start, abort       begin a block (IDLE only); synchronous cancel (wins over everything)
//   in_ready           plaintext byte consumed this cycle (LOAD)
//   perm_en, mc_en     byte permutation enable; mix_col accumulate enable
//   pts_en             pts_converter parallel-load strobe
//   last_round         final round: mix_col bypassed
//   key_req            round-key byte wanted at {round_cnt, byte_cnt}
//   byte_cnt[3:0]      byte index within the current phase
//   round_cnt[3:0]     0 = LOAD, 1..NUM_ROUNDS = rounds, NUM_ROUNDS+1 = DRAIN
//   out_valid          ciphertext byte valid (DRAIN)
//   busy, done         block in flight; one-cycle completion pulse
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       in_ready,
  output logic       perm_en,
  output logic       mc_en,
  output logic       pts_en,
  output logic       last_round,
  output logic       key_req,
  output logic [3:0] byte_cnt,
  output logic [3:0] round_cnt,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);
  localparam logic [3:0] DRAIN_RND = 4'(NUM_ROUNDS + 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] round_inc;
  logic       last_byte;
  logic       cnt_en;
  logic       cnt_clr;

  // Byte counter runs through every active phase and wraps into the next
  // phase by itself; it is frozen in DONE (already wrapped to 0) and held
  // clear in IDLE or on abort so every block starts at byte 0.
  assign cnt_en  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign cnt_clr = abort || (state_q == ST_IDLE);

  aes_round_sequencer_counter u_byte_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (byte_cnt)
  );

  assign last_byte = is_last_byte(byte_cnt);
  assign round_inc = round_q + 4'd1;
  assign round_cnt = round_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next state, round counter and enable decode. Outputs depend only on
  // state_q and the counters, never directly on start/abort.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    in_ready   = 1'b0;
    perm_en    = 1'b0;
    mc_en      = 1'b0;
    pts_en     = 1'b0;
    last_round = 1'b0;
    key_req    = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          round_d = 4'd0;
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        perm_en  = 1'b1;
        key_req  = 1'b1;
        if (last_byte) begin
          round_d = 4'd1;
          state_d = (LAST_RND == 4'd1) ? ST_FINAL : ST_ROUND;
        end
      end

      ST_ROUND: begin
        perm_en = 1'b1;
        key_req = 1'b1;
        // mix_col restarts its column accumulation on byte 0 of each column.
        mc_en   = (byte_cnt[1:0] != 2'b00);
        pts_en  = last_byte;
        if (last_byte) begin
          round_d = round_inc;
          state_d = (round_inc == LAST_RND) ? ST_FINAL : ST_ROUND;
        end
      end

      ST_FINAL: begin
        perm_en    = 1'b1;
        key_req    = 1'b1;
        last_round = 1'b1;
        pts_en     = last_byte;
        if (last_byte) begin
          round_d = DRAIN_RND;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        out_valid = 1'b1;
        if (last_byte) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        round_d = 4'd0;
      end

      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      round_d = 4'd0;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three instances (10, 14 and 1 rounds) share
// start/abort/rst and are compared every cycle against a cycle-index model.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;

  always #5 clk = ~clk;

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : ((i == 1) ? 14 : 1);
  endfunction

  logic       in_ready_w   [3];
  logic       perm_en_w    [3];
  logic       mc_en_w      [3];
  logic       pts_en_w     [3];
  logic       last_round_w [3];
  logic       key_req_w    [3];
  logic [3:0] byte_w       [3];
  logic [3:0] round_w      [3];
  logic       out_valid_w  [3];
  logic       busy_w       [3];
  logic       done_w       [3];
  logic [16:0] vec         [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_sequencer #(.NUM_ROUNDS(nr_of(g))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .in_ready   (in_ready_w[g]),
      .perm_en    (perm_en_w[g]),
      .mc_en      (mc_en_w[g]),
      .pts_en     (pts_en_w[g]),
      .last_round (last_round_w[g]),
      .key_req    (key_req_w[g]),
      .byte_cnt   (byte_w[g]),
      .round_cnt  (round_w[g]),
      .out_valid  (out_valid_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g])
    );
    assign vec[g] = {in_ready_w[g], perm_en_w[g], mc_en_w[g], pts_en_w[g],
                     last_round_w[g], key_req_w[g], byte_w[g], round_w[g],
                     out_valid_w[g], busy_w[g], done_w[g]};
  end

  // Model state: tm = cycle number within the block (0 = idle, 1 = first
  // LOAD cycle, 16*(nr+2)+1 = done cycle).
  int tm [3];
  int checks = 0;
  int errors = 0;
  int cyc;
  int first_done [3];

  // Expected output vector, same packing as vec, from the cycle number.
  function automatic logic [16:0] exp_vec(input int nr, input int t);
    logic [16:0] v;
    int p, b;
    v = '0;
    if (t == 0) return v;
    p = (t - 1) / 16;
    b = (t - 1) % 16;
    v[1] = 1'b1;
    if (p <= nr + 1) begin
      v[6:3]  = 4'(p);
      v[10:7] = 4'(b);
    end else begin
      v[6:3]  = 4'(nr + 1);
      v[10:7] = 4'd0;
    end
    if (p == 0) begin
      v[16] = 1'b1; v[15] = 1'b1; v[11] = 1'b1;
    end else if (p < nr) begin
      v[15] = 1'b1; v[11] = 1'b1;
      v[14] = (b % 4 != 0);
      v[13] = (b == 15);
    end else if (p == nr) begin
      v[15] = 1'b1; v[11] = 1'b1; v[12] = 1'b1;
      v[13] = (b == 15);
    end else if (p == nr + 1) begin
      v[2] = 1'b1;
    end else begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [16:0] e;
    for (int i = 0; i < 3; i++) begin
      e = exp_vec(nr_of(i), tm[i]);
      checks++;
      assert (vec[i] === e) else begin
        errors++;
        $error("FAIL %s nr=%0d t=%0d observed=%h expected=%h", tag, nr_of(i), tm[i], vec[i], e);
      end
    end
  endtask

  task automatic step(input logic s, input logic a, input string tag);
    start = s;
    abort = a;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (a) tm[i] = 0;
      else if (tm[i] == 0) tm[i] = s ? 1 : 0;
      else if (tm[i] == 16 * (nr_of(i) + 2) + 1) tm[i] = 0;
      else tm[i] = tm[i] + 1;
    end
    cyc++;
    #1;
    check_all(tag);
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1 && first_done[i] == 0) first_done[i] = cyc;
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      tm[i] = 0;
      first_done[i] = 0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, "idle");

    // Nominal block with random extra starts while busy (forced one in round 3).
    cyc = 0;
    for (int i = 0; i < 3; i++) first_done[i] = 0;
    step(1'b1, 1'b0, "start");
    while (cyc < 262) begin
      step((cyc == 50) || ($urandom_range(0, 7) == 0), 1'b0, "run");
    end
    check_val("latency_nr10", first_done[0], 193);
    check_val("latency_nr14", first_done[1], 257);
    check_val("latency_nr1",  first_done[2], 49);
    step(1'b0, 1'b1, "abort_all");

    // Abort at LOAD byte 7: back to IDLE, no done afterwards.
    step(1'b1, 1'b0, "load");
    repeat (7) step(1'b0, 1'b0, "load");
    check_val("load_byte7", int'(byte_w[0]), 7);
    step(1'b0, 1'b1, "abort_load");
    check_val("abort_busy", int'(busy_w[0]), 0);
    repeat (20) step(1'b0, 1'b0, "post_abort");

    // Abort and start together in IDLE: stay idle.
    step(1'b1, 1'b1, "abort_start");
    step(1'b0, 1'b0, "abort_start_idle");

    // Asynchronous reset mid-ROUND with round_cnt = 4.
    step(1'b1, 1'b0, "pre_reset");
    repeat (69) step(1'b0, 1'b0, "pre_reset");
    check_val("round4", int'(round_w[0]), 4);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tm[i] = 0;
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, "after_reset");

    // Random start/abort traffic.
    repeat (600) step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
